// File: rtl/pinball_game_sequencer_if.sv
// Game-sequencer bus: playfield events in, game state, gating and score out.
interface pinball_game_sequencer_if;
    logic        i_animate;
    logic        i_start;
    logic        i_launch;
    logic        i_drain;
    logic [3:0]  i_hit;
    logic [2:0]  o_state;
    logic        o_ball_en;
    logic        o_flip_en;
    logic        o_launch;
    logic [5:0]  o_strength;
    logic [1:0]  o_balls_left;
    logic [11:0] o_score;
    logic [3:0]  o_hit_ack;
    logic        o_finish;

    modport master (
        output i_animate, i_start, i_launch, i_drain, i_hit,
        input  o_state, o_ball_en, o_flip_en, o_launch, o_strength,
        input  o_balls_left, o_score, o_hit_ack, o_finish
    );

    modport slave (
        input  i_animate, i_start, i_launch, i_drain, i_hit,
        output o_state, o_ball_en, o_flip_en, o_launch, o_strength,
        output o_balls_left, o_score, o_hit_ack, o_finish
    );
endinterface

// File: rtl/pinball_game_sequencer.sv
// Pinball game FSM, round-robin target-hit arbiter and saturating BCD score.
// Optional extra ball at 500 points: define PINBALL_EXTRA_BALL_EN.
module pinball_game_sequencer #(
    parameter int unsigned BALLS_PER_GAME = 3,
    parameter int unsigned CHARGE_MAX     = 63,
    parameter int unsigned DRAIN_FRAMES   = 60,
    parameter int unsigned HEX_POINTS     = 10,
    parameter int unsigned CIRC_POINTS    = 5
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    pinball_game_sequencer_if.slave  bus
);
    localparam int unsigned CNT_W  = $clog2(DRAIN_FRAMES + 1);
    localparam logic [3:0]  HEX_T  = 4'(HEX_POINTS / 10);
    localparam logic [3:0]  HEX_U  = 4'(HEX_POINTS % 10);
    localparam logic [3:0]  CIRC_T = 4'(CIRC_POINTS / 10);
    localparam logic [3:0]  CIRC_U = 4'(CIRC_POINTS % 10);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CHARGE = 3'd2,
        ST_LAUNCH = 3'd3,
        ST_PLAY   = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_OVER   = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic               start_prev_q, start_prev_d;
    logic               launch_prev_q, launch_prev_d;
    logic [5:0]         strength_q, strength_d;
    logic [1:0]         balls_q, balls_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         pending_q, pending_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [3:0]         ack_q, ack_d;
    logic [11:0]        score_q, score_d;
    logic               launch_q, launch_d;
    logic               ball_en_q, ball_en_d;
    logic               flip_en_q, flip_en_d;
    logic               finish_q, finish_d;
`ifdef PINBALL_EXTRA_BALL_EN
    logic               awarded_q, awarded_d;
`endif

    logic               accept, found, start_fire;
    logic [1:0]         idx;
    logic [3:0]         grant, pt, pu;
    logic [4:0]         u_sum, t_sum, h_sum;
    logic               uc, tc;
    logic [11:0]        score_sum;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            start_prev_q  <= 1'b1;
            launch_prev_q <= 1'b0;
            strength_q    <= '0;
            balls_q       <= '0;
            cnt_q         <= '0;
            pending_q     <= '0;
            ptr_q         <= '0;
            ack_q         <= '0;
            score_q       <= '0;
            launch_q      <= 1'b0;
            ball_en_q     <= 1'b0;
            flip_en_q     <= 1'b0;
            finish_q      <= 1'b0;
`ifdef PINBALL_EXTRA_BALL_EN
            awarded_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            start_prev_q  <= start_prev_d;
            launch_prev_q <= launch_prev_d;
            strength_q    <= strength_d;
            balls_q       <= balls_d;
            cnt_q         <= cnt_d;
            pending_q     <= pending_d;
            ptr_q         <= ptr_d;
            ack_q         <= ack_d;
            score_q       <= score_d;
            launch_q      <= launch_d;
            ball_en_q     <= ball_en_d;
            flip_en_q     <= flip_en_d;
            finish_q      <= finish_d;
`ifdef PINBALL_EXTRA_BALL_EN
            awarded_q     <= awarded_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        strength_d    = strength_q;
        balls_d       = balls_q;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        score_d       = score_q;
        start_prev_d  = bus.i_start;
        launch_prev_d = bus.i_launch;
        start_fire    = bus.i_start & ~start_prev_q;
        accept        = (state_q == ST_PLAY) || (state_q == ST_DRAIN);
`ifdef PINBALL_EXTRA_BALL_EN
        awarded_d     = awarded_q;
`endif

        // Round-robin grant over registered pending hits, starting at ptr_q
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < 4; i++) begin
            idx = 2'(ptr_q + 2'(i));
            if (!found && accept && pending_q[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                ptr_d      = 2'(idx + 2'd1);
            end
        end
        pending_d = (pending_q & ~grant) | (accept ? bus.i_hit : 4'b0000);
        ack_d     = grant;

        // BCD add of the previous cycle's grant, saturating at 999
        pt = '0;
        pu = '0;
        if (ack_q[0] || ack_q[1]) begin
            pt = HEX_T;
            pu = HEX_U;
        end else if (ack_q[2] || ack_q[3]) begin
            pt = CIRC_T;
            pu = CIRC_U;
        end
        u_sum = {1'b0, score_q[3:0]} + {1'b0, pu};
        uc    = u_sum > 5'd9;
        t_sum = {1'b0, score_q[7:4]} + {1'b0, pt} + {4'b0000, uc};
        tc    = t_sum > 5'd9;
        h_sum = {1'b0, score_q[11:8]} + {4'b0000, tc};
        score_sum = {h_sum[3:0],
                     tc ? 4'(t_sum - 5'd10) : t_sum[3:0],
                     uc ? 4'(u_sum - 5'd10) : u_sum[3:0]};
        if (h_sum > 5'd9) begin
            score_sum = 12'h999;
        end
        if (ack_q != 4'b0000) begin
            score_d = score_sum;
        end

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_fire) begin
                    state_d = ST_LOAD;
                    score_d = '0;
                    balls_d = 2'(BALLS_PER_GAME);
`ifdef PINBALL_EXTRA_BALL_EN
                    awarded_d = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                if (bus.i_launch && !launch_prev_q) begin
                    state_d    = ST_CHARGE;
                    strength_d = '0;
                end
            end
            ST_CHARGE: begin
                if (bus.i_animate && strength_q != 6'(CHARGE_MAX)) begin
                    strength_d = 6'(strength_q + 6'd1);
                end
                if (!bus.i_launch) begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_d = ST_PLAY;
            ST_PLAY: begin
                if (bus.i_drain) begin
                    state_d = ST_DRAIN;
                    balls_d = 2'(balls_q - 2'd1);
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                if (bus.i_animate) begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                    if (cnt_d == CNT_W'(DRAIN_FRAMES)) begin
                        state_d = (balls_q != 2'd0) ? ST_LOAD : ST_OVER;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Leftover hits from the drained ball never carry into the next one
        if (state_d == ST_LOAD && state_q != ST_LOAD) begin
            pending_d = '0;
        end

`ifdef PINBALL_EXTRA_BALL_EN
        if (!awarded_q && score_q[11:8] < 4'd5 && score_d[11:8] >= 4'd5) begin
            awarded_d = 1'b1;
            if (balls_d != 2'd3) begin
                balls_d = 2'(balls_d + 2'd1);
            end
        end
`endif

        launch_d  = (state_d == ST_LAUNCH);
        ball_en_d = (state_d == ST_LAUNCH) || (state_d == ST_PLAY);
        flip_en_d = (state_d == ST_PLAY);
        finish_d  = (state_d == ST_OVER);
    end

    assign bus.o_state      = state_q;
    assign bus.o_ball_en    = ball_en_q;
    assign bus.o_flip_en    = flip_en_q;
    assign bus.o_launch     = launch_q;
    assign bus.o_strength   = strength_q;
    assign bus.o_balls_left = balls_q;
    assign bus.o_score      = score_q;
    assign bus.o_hit_ack    = ack_q;
    assign bus.o_finish     = finish_q;
endmodule

// File: tb/tb_pinball_game_sequencer.sv
// Directed bench for pinball_game_sequencer: vector table plus game-flow sequences.
module tb_pinball_game_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

`ifdef PINBALL_EXTRA_BALL_EN
    localparam int BALLS_AFTER_500 = 2;
`else
    localparam int BALLS_AFTER_500 = 1;
`endif

    pinball_game_sequencer_if bus ();

    pinball_game_sequencer dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, start, launch, animate, drain;
        logic [3:0]  hit;
        logic [2:0]  st;
        logic [1:0]  balls;
        logic [11:0] score;
        logic [3:0]  ack;
        logic        lau;
        logic [5:0]  str;
        logic        ben, fen, fin;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic s, input logic l, input logic a,
                       input logic d, input logic [3:0] h, input logic [2:0] st,
                       input logic [1:0] b, input logic [11:0] sc, input logic [3:0] ak,
                       input logic lau, input logic [5:0] str, input logic ben,
                       input logic fen, input logic fin);
        vec_t v;
        v.rst = r; v.start = s; v.launch = l; v.animate = a; v.drain = d; v.hit = h;
        v.st = st; v.balls = b; v.score = sc; v.ack = ak; v.lau = lau; v.str = str;
        v.ben = ben; v.fen = fen; v.fin = fin;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            bus.i_animate = 1'b1;
            step();
            bus.i_animate = 1'b0;
            step();
        end
    endtask

    task automatic hit(input logic [3:0] b);
        bus.i_hit = b;
        step();
        bus.i_hit = 4'b0000;
        step();
        step();
    endtask

    task automatic quick_launch();
        bus.i_launch = 1'b1;
        step();
        bus.i_launch = 1'b0;
        step();
        step();
    endtask

    initial begin
        logic [30:0] got, exp;
        int          left;

        bus.i_start = 1'b0; bus.i_launch = 1'b0; bus.i_animate = 1'b0;
        bus.i_drain = 1'b0; bus.i_hit = 4'b0000;

        //    rst s l a d hit     st  b  score   ack     l str ben fen fin
        add(1, 0,0,0,0, 4'h0, 3'd0, 0, 12'h000, 4'h0, 0, 0, 0, 0, 0);
        add(0, 0,0,0,0, 4'h0, 3'd0, 0, 12'h000, 4'h0, 0, 0, 0, 0, 0);
        add(0, 1,0,0,0, 4'h0, 3'd1, 3, 12'h000, 4'h0, 0, 0, 0, 0, 0);
        add(0, 0,1,0,0, 4'h0, 3'd2, 3, 12'h000, 4'h0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++)
            add(0, 0,1,1,0, 4'h0, 3'd2, 3, 12'h000, 4'h0, 0, 6'(i), 0, 0, 0);
        add(0, 0,1,0,0, 4'h0, 3'd2, 3, 12'h000, 4'h0, 0, 10, 0, 0, 0);
        add(0, 0,0,0,0, 4'h0, 3'd3, 3, 12'h000, 4'h0, 1, 10, 1, 0, 0);
        add(0, 0,0,0,0, 4'h0, 3'd4, 3, 12'h000, 4'h0, 0, 10, 1, 1, 0);
        add(0, 0,0,0,0, 4'hf, 3'd4, 3, 12'h000, 4'h0, 0, 10, 1, 1, 0);
        add(0, 0,0,0,0, 4'h0, 3'd4, 3, 12'h000, 4'h1, 0, 10, 1, 1, 0);
        add(0, 0,0,0,0, 4'h0, 3'd4, 3, 12'h010, 4'h2, 0, 10, 1, 1, 0);
        add(0, 0,0,0,0, 4'h0, 3'd4, 3, 12'h020, 4'h4, 0, 10, 1, 1, 0);
        add(0, 0,0,0,0, 4'h0, 3'd4, 3, 12'h025, 4'h8, 0, 10, 1, 1, 0);
        add(0, 0,0,0,0, 4'h0, 3'd4, 3, 12'h030, 4'h0, 0, 10, 1, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst;
            bus.i_start = tbl[i].start; bus.i_launch = tbl[i].launch;
            bus.i_animate = tbl[i].animate; bus.i_drain = tbl[i].drain;
            bus.i_hit = tbl[i].hit;
            step();
            got = {bus.o_state, bus.o_balls_left, bus.o_score, bus.o_hit_ack, bus.o_launch,
                   bus.o_strength, bus.o_ball_en, bus.o_flip_en, bus.o_finish};
            exp = {tbl[i].st, tbl[i].balls, tbl[i].score, tbl[i].ack, tbl[i].lau,
                   tbl[i].str, tbl[i].ben, tbl[i].fen, tbl[i].fin};
            chk($sformatf("vec%0d", i), 32'(got), 32'(exp));
        end
        bus.i_hit = 4'b0000;

        // First drain, then the 60-frame drain window back to LOAD
        bus.i_drain = 1'b1; step(); bus.i_drain = 1'b0;
        chk("drain1_state", 32'(bus.o_state), 32'd5);
        chk("drain1_balls", 32'(bus.o_balls_left), 32'd2);
        frames(59);
        chk("drain1_59", 32'(bus.o_state), 32'd5);
        frames(1);
        chk("drain1_60", 32'(bus.o_state), 32'd1);

        // Long charge saturates strength
        bus.i_launch = 1'b1; step();
        chk("charge2_state", 32'(bus.o_state), 32'd2);
        frames(100);
        chk("charge2_sat", 32'(bus.o_strength), 32'd63);
        bus.i_launch = 1'b0; step();
        chk("launch2_pulse", 32'({bus.o_state, bus.o_launch, bus.o_strength}), 32'({3'd3, 1'b1, 6'd63}));
        step();
        chk("launch2_play", 32'({bus.o_state, bus.o_launch}), 32'({3'd4, 1'b0}));

        bus.i_drain = 1'b1; step(); bus.i_drain = 1'b0;
        chk("drain2_balls", 32'(bus.o_balls_left), 32'd1);
        frames(60);
        chk("drain2_load", 32'(bus.o_state), 32'd1);
        quick_launch();
        chk("ball3_play", 32'({bus.o_state, bus.o_strength}), 32'({3'd4, 6'd0}));

        // Score from 030 to 995, crossing 500 on the last ball
        for (int i = 0; i < 96; i++) hit(4'b0001);
        hit(4'b0100);
        chk("score_995", 32'(bus.o_score), 32'h995);
        chk("balls_500", 32'(bus.o_balls_left), 32'(BALLS_AFTER_500));
        hit(4'b0010);
        chk("score_sat", 32'(bus.o_score), 32'h999);
        hit(4'b1000);
        chk("score_nowrap", 32'(bus.o_score), 32'h999);
        chk("balls_once", 32'(bus.o_balls_left), 32'(BALLS_AFTER_500));

        left = BALLS_AFTER_500;
        while (left > 0) begin
            bus.i_drain = 1'b1; step(); bus.i_drain = 1'b0;
            left--;
            chk("drainN_balls", 32'(bus.o_balls_left), 32'(left));
            frames(60);
            chk("drainN_next", 32'(bus.o_state), (left != 0) ? 32'd1 : 32'd6);
            if (left != 0) quick_launch();
        end
        chk("over_finish", 32'({bus.o_finish, bus.o_balls_left, bus.o_ball_en}), 32'({1'b1, 2'd0, 1'b0}));

        // Hits in OVER are ignored
        bus.i_hit = 4'b0001; step();
        chk("over_ack0", 32'(bus.o_hit_ack), 32'd0);
        bus.i_hit = 4'b0000; step();
        chk("over_ack1", 32'(bus.o_hit_ack), 32'd0);
        step();
        chk("over_score", 32'(bus.o_score), 32'h999);

        // Restart from OVER
        bus.i_start = 1'b1; step(); bus.i_start = 1'b0;
        chk("restart", 32'({bus.o_state, bus.o_balls_left, bus.o_score, bus.o_finish}),
            32'({3'd1, 2'd3, 12'h000, 1'b0}));

        // Reset during CHARGE
        bus.i_launch = 1'b1; step();
        frames(3);
        chk("charge3_str", 32'({bus.o_state, bus.o_strength}), 32'({3'd2, 6'd3}));
        rst = 1'b1; step(); rst = 1'b0; bus.i_launch = 1'b0;
        chk("rst_charge", 32'({bus.o_state, bus.o_launch, bus.o_strength, bus.o_score, bus.o_balls_left}),
            32'({3'd0, 1'b0, 6'd0, 12'h000, 2'd0}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pinball_game_sequencer.md
Name: pinball_game_sequencer

Overview:
Central game controller for the pinball playfield. It sequences a game through start, plunger charge/launch, play, drain and game-over. It gates the ball and flipper datapaths and arbitrates target-hit events from the four targets (two hexagons, two circles) into a single shared BCD score adder. The block sits between the collision logic and the ball/flipper/score-display modules, in the 100 MHz `i_clk` domain, and advances game timing on the `i_animate` frame strobe.

Parameters:
- BALLS_PER_GAME, 3, balls issued per game (1..3)
- CHARGE_MAX, 63, plunger strength saturation value (6-bit)
- DRAIN_FRAMES, 60, frames spent in DRAIN before the next ball or game over
- HEX_POINTS, 10, points per hexagon hit (BCD-encodable, ≤99)
- CIRC_POINTS, 5, points per circle hit (≤99)

Ports:
- i_clk  in  1  system clock (100 MHz)
- i_rst  in  1  synchronous reset, active-high
- i_animate  in  1  one-cycle frame strobe at end of active video
- i_start  in  1  start request, level, already debounced
- i_launch  in  1  launch button, level, active-high (already inverted)
- i_drain  in  1  ball left playfield, one-cycle pulse
- i_hit  in  4  target hit pulses: [0]=hex1, [1]=hex2, [2]=circ1, [3]=circ2
- o_state  out  3  current FSM state encoding
- o_ball_en  out  1  ball physics enabled
- o_flip_en  out  1  flipper buttons honoured
- o_launch  out  1  one-cycle launch pulse
- o_strength  out  6  plunger strength, valid while o_launch=1
- o_balls_left  out  2  balls remaining, including the one in play
- o_score  out  12  3-digit BCD score {hundreds, tens, units}
- o_hit_ack  out  4  one-hot grant, one cycle, when a pending hit is scored
- o_finish  out  1  high in GAME_OVER

Behaviour:
- Reset: the FSM goes to IDLE. All outputs are 0, except o_balls_left = 0, o_score = 12'h000 and o_state = IDLE. Hit pending latches are cleared and the round-robin pointer is set to 0.
- States (o_state): IDLE=0, LOAD=1, CHARGE=2, LAUNCH=3, PLAY=4, DRAIN=5, OVER=6.
- IDLE: on i_start=1, go to LOAD. Score clears to 0 and balls_left is set to BALLS_PER_GAME in the same edge.
- LOAD: the ball is parked at the plunger. When i_launch rises (registered edge detect), go to CHARGE with strength=0.
- CHARGE: on each i_animate, strength increments and saturates at CHARGE_MAX. When i_launch falls, go to LAUNCH.
- LAUNCH: exactly one cycle. o_launch=1 and o_strength holds the latched value. Next state is PLAY.
- PLAY: o_ball_en=1 and o_flip_en=1 (o_ball_en is also 1 in LAUNCH). i_drain=1 moves to DRAIN; balls_left decrements in the same edge.
- DRAIN: a frame counter counts i_animate pulses. When the count reaches DRAIN_FRAMES, go to LOAD if balls_left≠0, else OVER.
- OVER: o_finish=1. i_start=1 restarts the game as in IDLE.
- A fresh i_start must be observed: a start level held from OVER does not re-trigger until it has been seen low for one cycle.
- Hit arbitration:
  - Each i_hit bit sets a sticky pending bit.
  - Hits are accepted only in PLAY and DRAIN; they are ignored in all other states.
  - One grant per cycle, round-robin starting from the pointer; the pointer moves to granted+1 mod 4.
  - The granted pending bit clears and o_hit_ack pulses.
  - A new pulse on the same bit in the same cycle as its grant re-sets pending, so no hit is lost.
- Score adder:
  - Adds points (HEX_POINTS for bits 0-1, CIRC_POINTS for bits 2-3) in BCD, with decimal carry per digit, result registered the cycle after the grant.
  - Score saturates at 999 and never wraps.
- Simultaneous events:
  - i_drain and a grant in the same cycle: both take effect.
  - Pending bits are cleared on the LOAD entry that follows DRAIN.
- Reset mid-operation (any state) has the same effect as the reset described above.

Optional Feature:
- Macro: PINBALL_EXTRA_BALL_EN.
- Defined: when the score first crosses from <500 to ≥500 in a game, balls_left increments, saturating at 3. An internal flag blocks a second award until the next game start.
- Undefined: no extra-ball logic is present, and balls_left only decrements.

Test Plan:
- Reset, then i_start=1 for 1 cycle → state LOAD, o_balls_left=3, o_score=000, o_finish=0.
- In LOAD: raise i_launch, deliver 10 i_animate strobes, drop i_launch → one-cycle o_launch with o_strength=10, then state PLAY with o_ball_en=1 and o_flip_en=1. Holding for 100 frames gives o_strength=63.
- In PLAY: i_hit=4'b1111 in one cycle → o_hit_ack is 0001, 0010, 0100, 1000 on consecutive cycles; final o_score=12'h030.
- Three drains, each followed by 60 frames → state OVER, o_finish=1, o_balls_left=0. An i_hit pulse in OVER gives no ack and no score change.
- Preload the score to 995 via hits, then a hex hit → o_score=12'h999, no wrap. With PINBALL_EXTRA_BALL_EN, crossing 500 with o_balls_left=1 gives o_balls_left=2 exactly once.
- Assert i_rst during CHARGE → next cycle state IDLE, o_launch=0, o_strength=0, o_score=000.
